fifo4x8_ctrl: RTL
=================

# fifo4x8_ctrl

Single-port FIFO sequencer that sits directly upstream of the 4x8 RAM and drives its address, read/write and data-in pins. It converts independent push and pop request streams into one RAM access per cycle and tracks occupancy with wrapping 2-bit pointers. Read data from the RAM is registered and returned to the consumer with a valid pulse.

## Interface
- DEPTH, 4, number of RAM words; must be a power of two
- WIDTH, 8, data word width
- AW, 2, address width, equal to log2(DEPTH)

- clock  in  1  single clock; all state changes on the rising edge
- clear  in  1  asynchronous, active-high reset
- push  in  1  write request; held until push_ack
- push_data  in  WIDTH  word to write; stable while push is high
- push_ack  out  1  write issued this cycle; combinational
- pop  in  1  read request; held until pop_ack
- pop_ack  out  1  read issued this cycle; combinational
- pop_data  out  WIDTH  registered read word
- pop_valid  out  1  pop_data valid; one-cycle pulse
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  AW+1  number of stored words, 0..DEPTH
- err  out  1  sticky protocol error; see Configuration
- ram_address  out  AW  to RAM address
- ram_rw  out  1  to RAM; 1 = write on this rising edge, 0 = read
- ram_i  out  WIDTH  to RAM write data
- ram_o  in  WIDTH  from RAM; asynchronous read of ram_address

## Operation
- Eligibility: push is eligible when push is high and full is low. pop is eligible when pop is high and empty is low.
- Grant:
  - Exactly one eligible request: that request is granted.
  - Both eligible: grant the one not granted on the most recent grant. The last-grant register resets to POP, so the first conflict goes to push.
- Push grant: push_ack=1, ram_rw=1, ram_address=wr_ptr, ram_i=push_data. At the edge, wr_ptr increments mod DEPTH (3 wraps to 0) and count increments.
- Pop grant: pop_ack=1, ram_rw=0, ram_address=rd_ptr. At the edge, pop_data captures ram_o, pop_valid is set, rd_ptr increments mod DEPTH and count decrements.
- No grant: ram_rw=0, ram_address=rd_ptr, ram_i=push_data. pop_valid is 0 on the next cycle.
- A push and a pop never complete in the same cycle, so count changes by at most 1 per cycle.
- Requests that are not granted are simply held by the requester; no state changes.

## Timing
- Reset values while clear is high: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, pop_data=0, pop_valid=0, err=0, last-grant=POP. push_ack, pop_ack and ram_rw are forced to 0.
- Write latency: the word is in the RAM at the edge that ends its push_ack cycle. It can be popped from the next cycle onward.
- Read latency: pop_valid is high exactly one cycle after the pop_ack cycle and returns to 0 unless another pop is granted.
- Back-to-back pops give a pop_valid pulse in every cycle.
- full and empty are derived from count and update in the cycle after the edge that changed count.
- clear asserted mid-operation: all state returns to reset values immediately. A write in that cycle is not guaranteed to land in the RAM.

## Configuration
- FIFO4X8_ERR_EN defined:
  - err is set at the edge when push is high while full is high, or when pop is high while empty is high.
  - err stays set until clear.
- FIFO4X8_ERR_EN undefined: err is tied to 0 and no error logic is built.
- Grant behaviour is identical in both builds.

## Structure
- Package fifo4x8_pkg holds:
  - DEPTH, WIDTH and AW defaults
  - grant enum {GNT_NONE, GNT_PUSH, GNT_POP}
- Sub-module fifo4x8_arbiter takes the two eligibility bits and outputs the grant enum. It holds the last-grant register.
- fifo4x8_ctrl holds the pointers, count, output register and err logic.

## Test plan
- Reset, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> ram_address 0,1,2,3 with ram_rw=1, count=4, full=1, push_ack low for a further push.
- From full, pop four times -> pop_valid pulses with pop_data 0x11, 0x22, 0x33, 0x44 in order, each one cycle after its pop_ack, then empty=1.
- Wrap-around: push 6 words and pop 6 words interleaved -> wr_ptr and rd_ptr pass 3 to 0, and data order is preserved.
- count=2 with push and pop both held -> grants alternate push, pop, push, pop starting with push, and count stays within 1..3.
- With FIFO4X8_ERR_EN, pop when empty -> err=1 at the next edge and stays 1 until clear. Without the macro, err stays 0.
- clear asserted while count=3 -> count=0, empty=1, pop_valid=0 immediately.

Source files
------------

// File: rtl/fifo4x8_pkg.sv
// fifo4x8 shared parameters and grant encoding.
package fifo4x8_pkg;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int AW    = 2;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PUSH,
        GNT_POP
    } gnt_e;

endpackage

// File: rtl/fifo4x8_if.sv
// fifo4x8 producer/consumer handshake and status bundle.
interface fifo4x8_if;
    import fifo4x8_pkg::*;

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             push_ack;
    logic             pop;
    logic             pop_ack;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             err;

    modport master (
        output push, push_data, pop,
        input  push_ack, pop_ack, pop_data, pop_valid,
        input  full, empty, count, err
    );

    modport slave (
        input  push, push_data, pop,
        output push_ack, pop_ack, pop_data, pop_valid,
        output full, empty, count, err
    );

endinterface

// File: rtl/fifo4x8_arbiter.sv
// fifo4x8 push/pop arbiter; alternates on conflict, last grant resets to pop.
module fifo4x8_arbiter
    import fifo4x8_pkg::*;
(
    input  logic clock,
    input  logic clear,
    input  logic push_ok,
    input  logic pop_ok,
    output gnt_e gnt
);

    gnt_e last, last_n;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) last <= GNT_POP;
        else       last <= last_n;
    end

    always_comb begin
        gnt    = GNT_NONE;
        last_n = last;
        unique case (1'b1)
            (push_ok && pop_ok):
                gnt = (last == GNT_POP) ? GNT_PUSH : GNT_POP;
            (push_ok && !pop_ok):
                gnt = GNT_PUSH;
            (!push_ok && pop_ok):
                gnt = GNT_POP;
            default:
                gnt = GNT_NONE;
        endcase
        if (gnt != GNT_NONE) last_n = gnt;
    end

endmodule

// File: rtl/fifo4x8_ctrl.sv
// fifo4x8 single-port RAM sequencer: pointers, count, read register.
// Optional sticky protocol error flag built under FIFO4X8_ERR_EN.
module fifo4x8_ctrl
    import fifo4x8_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    fifo4x8_if.slave         bus,
    output logic [AW-1:0]    ram_address,
    output logic             ram_rw,
    output logic [WIDTH-1:0] ram_i,
    input  logic [WIDTH-1:0] ram_o
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic             full, empty;
    logic             do_push, do_pop;
    gnt_e             gnt;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    fifo4x8_arbiter u_arb (
        .clock   (clock),
        .clear   (clear),
        .push_ok (bus.push && !full),
        .pop_ok  (bus.pop && !empty),
        .gnt     (gnt)
    );

    // Grants are masked while clear is held so the RAM sees no write.
    assign do_push = (gnt == GNT_PUSH) && !clear;
    assign do_pop  = (gnt == GNT_POP) && !clear;

    assign ram_rw      = do_push;
    assign ram_address = do_push ? wr_ptr : rd_ptr;
    assign ram_i       = bus.push_data;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                count    <= count - CNT_ONE;
                pop_data <= ram_o;
            end
        end
    end

`ifdef FIFO4X8_ERR_EN
    logic err;

    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            err <= 1'b0;
        else if ((bus.push && full) || (bus.pop && empty))
            err <= 1'b1;
    end

    assign bus.err = err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.push_ack  = do_push;
    assign bus.pop_ack   = do_pop;
    assign bus.pop_data  = pop_data;
    assign bus.pop_valid = pop_valid;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count;

endmodule
